main_mem_arbiter: RTL and testbench
===================================

Name: main_mem_arbiter

Overview:
- Shares the single port of the main data RAM (12-bit address, 16-bit data) between two requesters.
  - Requester 0 is the processor data port.
  - Requester 1 is a debug/DMA loader.
- Arbitration is round-robin, with one-cycle registered grants and a registered read-data return.
- Sits between the requesters and the RAM. The RAM is clocked on the inverted system clock, so an address driven after a rising edge is sampled at the following falling edge.

Parameters:
- AW, 12, address width.
- DW, 16, data width.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- n_reset  in  1  asynchronous, active-low reset.
- r0_req  in  1  requester 0 access request; held with its address/data until a grant is seen.
- r0_we  in  1  requester 0: 1 = write, 0 = read.
- r0_addr  in  AW  requester 0 address.
- r0_wdata  in  DW  requester 0 write data.
- r0_gnt  out  1  one-cycle pulse: requester 0 access is being performed this cycle.
- r0_rvalid  out  1  one-cycle pulse: r0_rdata is valid (reads only).
- r0_rdata  out  DW  requester 0 read data; holds its value until the next requester 0 read completes.
- r1_req, r1_we, r1_addr, r1_wdata, r1_gnt, r1_rvalid, r1_rdata: same meanings for requester 1.
- m_addr  out  AW  RAM address.
- m_data  out  DW  RAM write data.
- m_wren  out  1  RAM write enable.
- m_q  in  DW  RAM read data; valid before the rising edge that follows the address cycle.

Behaviour:
- Reset (n_reset = 0, asynchronous):
  - all outputs are 0;
  - last-winner pointer = 1, so requester 0 wins the first tie;
  - pending-read flags are cleared.
- Reset asserted mid-access:
  - the access is abandoned, and no gnt or rvalid is produced for it;
  - a write whose m_wren was already high may or may not have landed in RAM; software must not rely on it.
- Eligibility, evaluated at each rising edge:
  - requester i is eligible when ri_req = 1 and ri_gnt is currently 0;
  - this keeps a requester's stale req from being re-granted in the edge where it sees its grant;
  - consequence: a single requester gets at most one access every 2 cycles; the two requesters may alternate back-to-back.
- Arbitration:
  - exactly one eligible requester: it wins;
  - both eligible: the requester that is not the last winner wins;
  - the pointer updates only when a grant is issued.
- Grant cycle (registered):
  - the winner's gnt goes to 1 for exactly one cycle;
  - m_addr and m_data are loaded from the winner;
  - m_wren = winner's we.
- No grant:
  - m_wren = 0 and both gnt = 0;
  - m_addr and m_data hold their previous values.
- Read return:
  - at the edge ending a read grant cycle, m_q is captured into the winner's rdata and that rvalid pulses for one cycle;
  - latency: gnt at cycle N, rvalid/rdata at cycle N+1;
  - the other requester's rdata is untouched.
- Write: no rvalid is produced; the write completes within the grant cycle.
- Simultaneous events: a read return for one requester coincides freely with a new grant to either requester.
- Requester contract:
  - hold req, we, addr and wdata stable until gnt is sampled 1;
  - at that edge, drop req or present the next request.
- Arbitration and pointer state together form a 3-state FSM:
  - IDLE: no grant;
  - G0: requester 0 granted;
  - G1: requester 1 granted.
- Transitions follow the rules above. G0 → G0 and G1 → G1 are impossible by the eligibility rule.

Optional Feature:
- Macro: MAIN_MEM_ARB_STATS_EN.
- When defined, adds two outputs, r0_stall_cnt and r1_stall_cnt (16 bits each).
  - Each increments on every cycle in which ri_req = 1, ri_gnt = 0, and requester i was not the winner at that edge.
  - Each saturates at 16'hFFFF and resets to 0.
- When not defined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Single write: r0 writes addr 12'h010, data 16'hBEEF → r0_gnt 1 cycle later with m_wren = 1, m_addr = 12'h010, m_data = 16'hBEEF; no r0_rvalid.
- Readback: r0 reads 12'h010 → r0_gnt at N, r0_rvalid at N+1 with r0_rdata = 16'hBEEF; r1_rdata unchanged.
- Contention: r0 and r1 request continuously from reset → grants r0, r1, r0, r1… with no idle cycles.
  - With STATS_EN defined: each stall count increments every other cycle.
- Solo streaming: r1 requests continuously with 4 reads to 0–3 → r1_gnt every second cycle, with m_wren = 0 in between.
  - Four rvalid pulses, each carrying the matching RAM contents.
- Reset: n_reset pulled low mid-read (after gnt, before rvalid) → all outputs 0 immediately, no rvalid.
  - After release, simultaneous requests → r0 granted first.
- Hold semantics: r1 requests write while r0 is granted → r1_gnt next cycle; m_data switches to the r1 value only in that cycle.

Source files
------------

// File: rtl/main_mem_arbiter.sv
// main_mem_arbiter: round-robin sharing of one RAM port between two requesters, registered grants and read return.
// Define MAIN_MEM_ARB_STATS_EN to add saturating per-requester stall counters.
module main_mem_arbiter #(
  parameter int AW = 12,
  parameter int DW = 16
) (
  input  logic          clock,
  input  logic          n_reset,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_rdata,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_data,
  output logic          m_wren,
`ifdef MAIN_MEM_ARB_STATS_EN
  output logic [15:0]   r0_stall_cnt,
  output logic [15:0]   r1_stall_cnt,
`endif
  input  logic [DW-1:0] m_q
);
  typedef enum logic [1:0] {IDLE, G0, G1} state_t;
  state_t state, state_nx;
  logic last, e0, e1, w0, w1;
  assign r0_gnt = state == G0;
  assign r1_gnt = state == G1;
  always_comb begin
    e0 = r0_req & ~r0_gnt;
    e1 = r1_req & ~r1_gnt;
    w0 = e0 & (~e1 | last);
    w1 = e1 & ~w0;
    state_nx = w0 ? G0 : w1 ? G1 : IDLE;
  end
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      m_addr    <= '0;
      m_data    <= '0;
      m_wren    <= 1'b0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
    end else begin
      state  <= state_nx;
      m_wren <= w0 ? r0_we : w1 & r1_we;
      if (w0 | w1) begin
        last   <= w1;
        m_addr <= w0 ? r0_addr : r1_addr;
        m_data <= w0 ? r0_wdata : r1_wdata;
      end
      // a grant cycle with m_wren low is a read whose m_q is ready at this edge
      r0_rvalid <= r0_gnt & ~m_wren;
      r1_rvalid <= r1_gnt & ~m_wren;
      if (r0_gnt & ~m_wren) r0_rdata <= m_q;
      if (r1_gnt & ~m_wren) r1_rdata <= m_q;
    end
  end
`ifdef MAIN_MEM_ARB_STATS_EN
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r0_stall_cnt <= '0;
      r1_stall_cnt <= '0;
    end else begin
      if (r0_req & ~w0 & ~&r0_stall_cnt) r0_stall_cnt <= r0_stall_cnt + 16'd1;
      if (r1_req & ~w1 & ~&r1_stall_cnt) r1_stall_cnt <= r1_stall_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_main_mem_arbiter.sv
// tb_main_mem_arbiter: directed checks of grants, read return, reset and round-robin order.
module tb_main_mem_arbiter;
  logic        clock = 1'b0;
  logic        n_reset = 1'b0;
  logic        r0_req = 1'b0, r0_we = 1'b0, r1_req = 1'b0, r1_we = 1'b0;
  logic [11:0] r0_addr = '0, r1_addr = '0;
  logic [15:0] r0_wdata = '0, r1_wdata = '0;
  logic        r0_gnt, r0_rvalid, r1_gnt, r1_rvalid, m_wren;
  logic [15:0] r0_rdata, r1_rdata, m_data;
  logic [15:0] m_q = '0;
  logic [11:0] m_addr;
  logic [15:0] mem [0:4095];
`ifdef MAIN_MEM_ARB_STATS_EN
  logic [15:0] r0_stall_cnt, r1_stall_cnt;
`endif
  int checks = 0;
  int errors = 0;

  main_mem_arbiter dut (
    .clock(clock), .n_reset(n_reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .m_addr(m_addr), .m_data(m_data), .m_wren(m_wren),
`ifdef MAIN_MEM_ARB_STATS_EN
    .r0_stall_cnt(r0_stall_cnt), .r1_stall_cnt(r1_stall_cnt),
`endif
    .m_q(m_q)
  );

  always #5 clock = ~clock;

  // RAM on the inverted clock
  always @(negedge clock) begin
    if (m_wren) mem[m_addr] <= m_data;
    m_q <= mem[m_addr];
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, m_wren} !== 5'b0 || m_addr !== 12'h0 || m_data !== 16'h0 ||
        r0_rdata !== 16'h0 || r1_rdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b%b rvalid=%b%b wren=%b addr=%h data=%h rd0=%h rd1=%h required all zero",
               r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, m_wren, m_addr, m_data, r0_rdata, r1_rdata);
    end
    step();
    n_reset = 1'b1;
  endtask

  task automatic test_write();
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 12'h010; r0_wdata = 16'hBEEF;
    step();
    checks++;
    if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0 || m_wren !== 1'b1 || m_addr !== 12'h010 || m_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL write_grant: gnt=%b%b wren=%b addr=%h data=%h required 10 1 010 beef", r0_gnt, r1_gnt, m_wren, m_addr, m_data);
    end
    r0_req = 1'b0;
    step();
    checks++;
    if (r0_gnt !== 1'b0 || r0_rvalid !== 1'b0 || m_wren !== 1'b0) begin
      errors++;
      $display("FAIL write_after: gnt=%b rvalid=%b wren=%b required 0 0 0", r0_gnt, r0_rvalid, m_wren);
    end
  endtask

  task automatic test_readback();
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 12'h010;
    step();
    checks++;
    if (r0_gnt !== 1'b1 || m_wren !== 1'b0 || m_addr !== 12'h010 || r0_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL read_grant: gnt=%b wren=%b addr=%h rvalid=%b required 1 0 010 0", r0_gnt, m_wren, m_addr, r0_rvalid);
    end
    r0_req = 1'b0;
    step();
    checks++;
    if (r0_rvalid !== 1'b1 || r0_rdata !== 16'hBEEF || r1_rdata !== 16'h0 || r1_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL read_return: rvalid=%b rdata=%h rd1=%h rvalid1=%b required 1 beef 0000 0", r0_rvalid, r0_rdata, r1_rdata, r1_rvalid);
    end
    step();
    checks++;
    if (r0_rvalid !== 1'b0 || r0_rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL read_hold: rvalid=%b rdata=%h required 0 beef", r0_rvalid, r0_rdata);
    end
  endtask

  task automatic test_stream();
    logic [15:0] exp [0:3];
    exp[0] = 16'hA000; exp[1] = 16'hA001; exp[2] = 16'hA002; exp[3] = 16'hA003;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 12'h000;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (r1_gnt !== 1'b1 || r0_gnt !== 1'b0 || m_addr !== 12'(i) || m_wren !== 1'b0) begin
        errors++;
        $display("FAIL stream_grant[%0d]: gnt=%b%b addr=%h wren=%b required 01 %h 0", i, r0_gnt, r1_gnt, m_addr, m_wren, 12'(i));
      end
      if (i == 3) r1_req = 1'b0;
      else r1_addr = 12'(i + 1);
      step();
      checks++;
      if (r1_gnt !== 1'b0 || m_wren !== 1'b0 || r1_rvalid !== 1'b1 || r1_rdata !== exp[i] || r0_rdata !== 16'hBEEF) begin
        errors++;
        $display("FAIL stream_return[%0d]: gnt=%b wren=%b rvalid=%b rdata=%h rd0=%h required 0 0 1 %h beef",
                 i, r1_gnt, m_wren, r1_rvalid, r1_rdata, r0_rdata, exp[i]);
      end
    end
  endtask

  task automatic test_hold();
    r0_req = 1'b1; r0_we = 1'b1; r0_addr = 12'h020; r0_wdata = 16'h1111;
    step();
    r0_req = 1'b0;
    r1_req = 1'b1; r1_we = 1'b1; r1_addr = 12'h030; r1_wdata = 16'h2222;
    checks++;
    if (r0_gnt !== 1'b1 || m_data !== 16'h1111 || m_addr !== 12'h020) begin
      errors++;
      $display("FAIL hold_first: gnt0=%b data=%h addr=%h required 1 1111 020", r0_gnt, m_data, m_addr);
    end
    step();
    r1_req = 1'b0;
    checks++;
    if (r1_gnt !== 1'b1 || r0_gnt !== 1'b0 || m_data !== 16'h2222 || m_addr !== 12'h030 || m_wren !== 1'b1) begin
      errors++;
      $display("FAIL hold_second: gnt=%b%b data=%h addr=%h wren=%b required 01 2222 030 1", r0_gnt, r1_gnt, m_data, m_addr, m_wren);
    end
    step();
    checks++;
    if (r1_gnt !== 1'b0 || m_wren !== 1'b0 || m_data !== 16'h2222 || r1_rvalid !== 1'b0 || mem[12'h030] !== 16'h2222) begin
      errors++;
      $display("FAIL hold_idle: gnt=%b wren=%b data=%h rvalid=%b mem=%h required 0 0 2222 0 2222",
               r1_gnt, m_wren, m_data, r1_rvalid, mem[12'h030]);
    end
  endtask

  task automatic test_reset_mid();
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 12'h010;
    step();
    r0_req = 1'b0;
    #3;
    n_reset = 1'b0;
    #1;
    checks++;
    if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, m_wren} !== 5'b0 || m_addr !== 12'h0 || r0_rdata !== 16'h0 || r1_rdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid: gnt=%b%b rvalid=%b%b wren=%b addr=%h rd0=%h rd1=%h required all zero",
               r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, m_wren, m_addr, r0_rdata, r1_rdata);
    end
    step();
    checks++;
    if (r0_rvalid !== 1'b0 || r0_rdata !== 16'h0) begin
      errors++;
      $display("FAIL reset_no_rvalid: rvalid=%b rdata=%h required 0 0000", r0_rvalid, r0_rdata);
    end
  endtask

  task automatic test_contention();
    n_reset = 1'b1;
    r0_req = 1'b1; r0_we = 1'b0; r0_addr = 12'h002;
    r1_req = 1'b1; r1_we = 1'b0; r1_addr = 12'h003;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (r0_gnt !== k[0] || r1_gnt !== ~k[0] || m_wren !== 1'b0) begin
        errors++;
        $display("FAIL contention_grant[%0d]: gnt=%b%b wren=%b required %b%b 0", k, r0_gnt, r1_gnt, m_wren, k[0], ~k[0]);
      end
      if (k >= 2) begin
        checks++;
        if (r0_rvalid !== ~k[0] || r1_rvalid !== (k[0] && k >= 3) ||
            (!k[0] && r0_rdata !== 16'hA002) || (k[0] && r1_rdata !== 16'hA003)) begin
          errors++;
          $display("FAIL contention_return[%0d]: rvalid=%b%b rd0=%h rd1=%h required rd0 a002 / rd1 a003",
                   k, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata);
        end
      end
    end
`ifdef MAIN_MEM_ARB_STATS_EN
    checks++;
    if (r0_stall_cnt !== 16'd3 || r1_stall_cnt !== 16'd3) begin
      errors++;
      $display("FAIL stall_counts: r0=%0d r1=%0d required 3 3", r0_stall_cnt, r1_stall_cnt);
    end
`endif
    r0_req = 1'b0; r1_req = 1'b0;
    step();
    step();
    checks++;
    if (r0_gnt !== 1'b0 || r1_gnt !== 1'b0 || m_wren !== 1'b0) begin
      errors++;
      $display("FAIL contention_idle: gnt=%b%b wren=%b required 00 0", r0_gnt, r1_gnt, m_wren);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
    mem[0] = 16'hA000; mem[1] = 16'hA001; mem[2] = 16'hA002; mem[3] = 16'hA003;
    test_reset();
    test_write();
    test_readback();
    test_stream();
    test_hold();
    test_reset_mid();
    test_contention();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
